// File: rtl/overture_pkg.sv
// Shared types and constants for the Overture trace observer.
package overture_pkg;

  localparam int unsigned OVT_DATA_W = 8;

  // Capture state encoding, kept as plain constants for legacy compatibility.
  typedef logic [1:0] trace_state_t;
  localparam trace_state_t ARMED = 2'd0;
  localparam trace_state_t TRACE = 2'd1;
  localparam trace_state_t DRAIN = 2'd2;
  localparam trace_state_t DONE  = 2'd3;

  // One trace record as seen by the consumer.
  typedef struct packed {
    logic [OVT_DATA_W-1:0] pc;
    logic [OVT_DATA_W-1:0] acc;
  } trace_rec_t;

endpackage

// File: rtl/overture_sync_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is dropped and flagged on 'dropped' for that cycle.
module overture_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       dropped
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             pop_ok;
  logic             push_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign pop_ok  = pop && !empty;
  // When full, wr_ptr == rd_ptr, so a simultaneous push overwrites the slot
  // being popped this same edge; the new record therefore lands at the tail.
  assign push_ok = push && (!full || pop_ok);
  assign dropped = push && full && !pop_ok;
  assign head_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care whenever the count excludes them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap modulo DEPTH; count moves by at most one per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/overture_trace_fifo.sv
// Observer for the Overture CPU: records {pc, acc} whenever the PC changes
// and streams the records out over a valid/ready interface.
module overture_trace_fifo
  import overture_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = OVT_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          cpu_pc,
  input  logic [DATA_W-1:0]          cpu_acc,
  input  logic                       cpu_halted,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_acc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       done
);

  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  trace_state_t              state;
  logic [DATA_W-1:0]         last_pc;
  logic                      push;
  logic                      pop_ok;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_dropped;
  logic                      drain_empty;
  logic [2*DATA_W-1:0]       head;
  logic [CNT_W-1:0]          fifo_count;

  overture_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({cpu_pc, cpu_acc}),
    .pop       (out_ready),
    .head_data (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .dropped   (fifo_dropped)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = head[2*DATA_W-1:DATA_W];
  assign out_acc   = head[DATA_W-1:0];
  assign count     = fifo_count;
  assign pop_ok    = out_valid && out_ready;
  // Occupancy after this cycle's pop, valid in DRAIN where no push occurs.
  assign drain_empty = (fifo_count == '0) || ((fifo_count == ONE_CNT) && pop_ok);

  // Capture decision: always on the first post-reset cycle, else on PC change.
  always_comb begin
    push = 1'b0;
    case (state)
      ARMED:   push = 1'b1;
      TRACE:   push = (cpu_pc != last_pc);
      default: push = 1'b0;
    endcase
  end

  // Capture state machine, sticky overflow and registered completion flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARMED;
      last_pc  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (fifo_dropped) begin
        overflow <= 1'b1;
      end
      done <= (state == DONE);
      case (state)
        ARMED: begin
          last_pc <= cpu_pc;
          state   <= TRACE;
        end
        TRACE: begin
          last_pc <= cpu_pc;
          if (cpu_halted) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_empty) begin
            state <= DONE;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_overture_trace_fifo.sv
// Directed bench for overture_trace_fifo (DEPTH=8 and DEPTH=2 instances).
module tb_overture_trace_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] pc, acc;
  logic       halted, ready;
  logic       v;
  logic [7:0] opc, oacc;
  logic [3:0] cnt;
  logic       ovf, dn;

  logic [7:0] pc2, acc2;
  logic       halted2, ready2;
  logic       v2;
  logic [7:0] opc2, oacc2;
  logic [1:0] cnt2;
  logic       ovf2, dn2;

  overture_trace_fifo #(.DEPTH(8), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .cpu_pc(pc), .cpu_acc(acc), .cpu_halted(halted),
    .out_valid(v), .out_ready(ready), .out_pc(opc), .out_acc(oacc),
    .count(cnt), .overflow(ovf), .done(dn)
  );

  overture_trace_fifo #(.DEPTH(2), .DATA_W(8)) dut2 (
    .clk(clk), .reset(reset), .cpu_pc(pc2), .cpu_acc(acc2), .cpu_halted(halted2),
    .out_valid(v2), .out_ready(ready2), .out_pc(opc2), .out_acc(oacc2),
    .count(cnt2), .overflow(ovf2), .done(dn2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  logic [7:0] seq_pc  [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0] seq_acc [5] = '{8'd0, 8'd3, 8'd8, 8'd10, 8'd10};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pc = '0; acc = '0; halted = 1'b0; ready = 1'b0;
    pc2 = '0; acc2 = '0; halted2 = 1'b0; ready2 = 1'b0;
    tick(); tick();

    check("rst_valid", v, 0);
    check("rst_count", cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_done", dn, 0);
    check("rst_pc", opc, 0);
    check("rst_acc", oacc, 0);

    // Math sequence streamed with ready held high.
    reset = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = seq_pc[i]; acc = seq_acc[i]; halted = (i == 4);
      tick();
      check("t1_valid", v, 1);
      check("t1_pc", opc, seq_pc[i]);
      check("t1_acc", oacc, seq_acc[i]);
      check("t1_count", cnt, 1);
    end
    tick();
    check("t1_empty_cnt", cnt, 0);
    check("t1_empty_v", v, 0);
    check("t1_done_early", dn, 0);
    tick();
    check("t1_done", dn, 1);
    check("t1_ovf", ovf, 0);
    tick();
    check("t1_pop_empty", cnt, 0);

    // Same sequence with ready low, then drain.
    halted = 1'b0; pc = '0; acc = '0; ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pc = seq_pc[i]; acc = seq_acc[i]; halted = (i == 4);
      tick();
      check("t2_count", cnt, i + 1);
      check("t2_head_pc", opc, 0);
    end
    tick(); tick();
    check("t2_hold_cnt", cnt, 5);
    check("t2_ovf", ovf, 0);
    check("t2_done_early", dn, 0);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t2_drain_pc", opc, seq_pc[i]);
      check("t2_drain_acc", oacc, seq_acc[i]);
      tick();
    end
    check("t2_drained", cnt, 0);
    check("t2_done_lag", dn, 0);
    tick();
    check("t2_done", dn, 1);

    // DEPTH=2 overflow.
    halted = 1'b0; ready = 1'b0; pc = '0; acc = '0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pc2 = 8'(i); acc2 = 8'(8'h20 + i);
      tick();
    end
    check("t3_count", cnt2, 2);
    check("t3_ovf", ovf2, 1);
    check("t3_head_pc", opc2, 0);
    check("t3_head_acc", oacc2, 8'h20);
    ready2 = 1'b1;
    tick();
    check("t3_second_pc", opc2, 1);
    check("t3_second_acc", oacc2, 8'h21);
    tick();
    check("t3_empty", v2, 0);
    check("t3_ovf_sticky", ovf2, 1);

    // Full FIFO with simultaneous push and pop.
    ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pc = 8'(i); acc = 8'(8'h10 + i);
      tick();
    end
    check("t4_full", cnt, 8);
    pc = 8'd8; acc = 8'h18; ready = 1'b1;
    tick();
    check("t4_cnt_same", cnt, 8);
    check("t4_ovf", ovf, 0);
    for (int k = 1; k <= 8; k++) begin
      check("t4_pc", opc, k);
      check("t4_acc", oacc, 8'h10 + k);
      tick();
    end
    check("t4_drained", cnt, 0);

    // Reset mid-trace, then constant pc with changing acc.
    ready = 1'b0; pc = '0; acc = '0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pc = 8'(i); tick();
    end
    check("t5_pre_cnt", cnt, 3);
    pc = 8'd5; acc = 8'h55; reset = 1'b1;
    tick();
    check("t5_rst_cnt", cnt, 0);
    check("t5_rst_valid", v, 0);
    check("t5_rst_ovf", ovf, 0);
    reset = 1'b0;
    tick();
    check("t5_armed_cnt", cnt, 1);
    check("t5_armed_pc", opc, 5);
    check("t5_armed_acc", oacc, 8'h55);
    acc = 8'h66; tick();
    acc = 8'h77; tick();
    check("t6_cnt", cnt, 1);
    check("t6_acc", oacc, 8'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
